// File: rtl/alu_multiword_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_multiword_seq_if: request, response and ALU-side bundle of the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface alu_multiword_seq_if #(
  parameter int N_B   = 32,
  parameter int WORDS = 2,
  parameter int LW    = $clog2(WORDS) + 1
);
  logic                 start;
  logic [3:0]           alu_op;
  logic [LW-1:0]        len;
  logic                 set_flags;
  logic [N_B*WORDS-1:0] a_in;
  logic [N_B*WORDS-1:0] b_in;
  logic [N_B-1:0]       alu_a;
  logic [N_B-1:0]       alu_b;
  logic [3:0]           alu_ctrl;
  logic                 alu_cin;
  logic [N_B-1:0]       alu_result;
  logic                 alu_cout;
  logic                 busy;
  logic                 done;
  logic [N_B*WORDS-1:0] result;
  logic [3:0]           flags;

  modport master (
    output start, alu_op, len, set_flags, a_in, b_in, alu_result, alu_cout,
    input  alu_a, alu_b, alu_ctrl, alu_cin, busy, done, result, flags
  );

  modport slave (
    input  start, alu_op, len, set_flags, a_in, b_in, alu_result, alu_cout,
    output alu_a, alu_b, alu_ctrl, alu_cin, busy, done, result, flags
  );
endinterface
`default_nettype wire

// File: rtl/alu_multiword_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_multiword_seq: word-serial carry-chained ALU sequencer with NZCV register
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_multiword_seq #(
  parameter int N_B   = 32,
  parameter int WORDS = 2,
  parameter int LW    = $clog2(WORDS) + 1
) (
  input  logic               clk,
  input  logic               reset,
  alu_multiword_seq_if.slave bus
);
  localparam int            IW          = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [LW-1:0] c_words_len = LW'(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [N_B*WORDS-1:0] r_a;
  logic [N_B*WORDS-1:0] r_b;
  logic [N_B*WORDS-1:0] r_result;
  logic [3:0]           r_op;
  logic                 r_set_flags;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        r_last;
  logic                 r_zacc;
  logic [N_B-1:0]       r_alu_a;
  logic [N_B-1:0]       r_alu_b;
  logic [3:0]           r_alu_ctrl;
  logic                 r_alu_cin;
  logic                 r_busy;
  logic                 r_done;
  logic [3:0]           r_flags;

  logic [LW-1:0]        w_eff_len;
  logic [IW-1:0]        w_last_idx;
  logic [IW-1:0]        w_next_idx;
  logic                 w_is_last;
  logic                 w_arith;
  logic                 w_word_zero;
  logic [3:0]           w_nzcv;

  always_comb begin
    w_eff_len = bus.len;
    if (bus.len == '0) begin
      w_eff_len = LW'(1);
    end else if (bus.len > c_words_len) begin
      w_eff_len = c_words_len;
    end
    w_last_idx = IW'(w_eff_len - LW'(1));
  end

  // Flags are formed from the top word while it is still on the ALU inputs;
  // b's msb is the un-inverted operand, so SUB overflow uses op[0] to flip it.
  always_comb begin
    w_next_idx  = r_idx + IW'(1);
    w_is_last   = (r_idx == r_last);
    w_arith     = ~r_op[1];
    w_word_zero = (bus.alu_result == '0);
    w_nzcv      = {bus.alu_result[N_B-1],
                   r_zacc & w_word_zero,
                   bus.alu_cout & w_arith,
                   ~(r_op[0] ^ r_alu_a[N_B-1] ^ r_alu_b[N_B-1]) &
                   (r_alu_a[N_B-1] ^ bus.alu_result[N_B-1]) & w_arith};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_op        <= '0;
      r_set_flags <= 1'b0;
      r_idx       <= '0;
      r_last      <= '0;
      r_zacc      <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= '0;
      r_alu_cin   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_flags     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_a         <= bus.a_in;
            r_b         <= bus.b_in;
            r_op        <= bus.alu_op;
            r_set_flags <= bus.set_flags;
            r_last      <= w_last_idx;
            r_idx       <= '0;
            r_zacc      <= 1'b1;
            r_result    <= '0;
            r_alu_a     <= bus.a_in[N_B-1:0];
            r_alu_b     <= bus.b_in[N_B-1:0];
            r_alu_ctrl  <= bus.alu_op;
            r_alu_cin   <= (bus.alu_op[1:0] == 2'b01);
          end
        end
        S_RUN: begin
          r_result[r_idx*N_B +: N_B] <= bus.alu_result;
          r_zacc <= r_zacc & w_word_zero;
          r_idx  <= w_next_idx;
          if (w_is_last) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= '0;
            r_alu_cin  <= 1'b0;
            if (r_set_flags) begin
              r_flags <= w_nzcv;
            end
          end else begin
            r_alu_a   <= r_a[w_next_idx*N_B +: N_B];
            r_alu_b   <= r_b[w_next_idx*N_B +: N_B];
            r_alu_cin <= bus.alu_cout & w_arith;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.alu_a    = r_alu_a;
  assign bus.alu_b    = r_alu_b;
  assign bus.alu_ctrl = r_alu_ctrl;
  assign bus.alu_cin  = r_alu_cin;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.flags    = r_flags;
endmodule
`default_nettype wire

// File: doc/alu_multiword_seq.md
Name: alu_multiword_seq

Overview:
- Sequences the shared N_b-bit ALU over multi-word operands, one word per cycle from least to most significant, chaining carry between words.
- Accumulates NZCV across words, with the same flag semantics as the single-word flags logic.
- Holds the architectural flag register, updated only on S-type operations.
- Sits between the decode/control unit and the ALU for wide arithmetic in the image-equalizer datapath.

Parameters:
- N_b, 32, ALU word width in bits
- WORDS, 2, maximum words per operation (≥1)
- LW, $clog2(WORDS)+1, width of the len port

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- alu_op  in  4  ALUControl encoding: [1:0]=00 ADD, 01 SUB, 10 AND, 11 OR; [3:2] ignored
- len  in  LW  number of words, 1..WORDS
- set_flags  in  1  S-bit; 1 = commit flags at completion
- a_in  in  N_b*WORDS  operand A, word 0 = bits [N_b-1:0]
- b_in  in  N_b*WORDS  operand B
- alu_a  out  N_b  current A word to the ALU
- alu_b  out  N_b  current B word to the ALU
- alu_ctrl  out  4  latched alu_op to the ALU
- alu_cin  out  1  carry-in to the ALU
- alu_result  in  N_b  ALU result; combinational in the same cycle
- alu_cout  in  1  ALU carry-out
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result  out  N_b*WORDS  assembled result; held after done
- flags  out  4  architectural {N,Z,C,V}

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state IDLE; busy=0, done=0
  - result=0, flags=4'b0000, internal carry/Z accumulators cleared
  - alu_a/alu_b/alu_ctrl/alu_cin=0
- States and transitions:
  - IDLE → RUN on start. Same edge latches a_in, b_in, alu_op, set_flags, and eff_len (len=0 or len>WORDS becomes 1 or WORDS respectively). Clears word index i=0, zacc=1, result=0.
  - RUN: busy=1. Drives word i onto alu_a/alu_b; alu_ctrl = latched op.
  - alu_cin:
    - ADD: 0 for i=0, else carry register
    - SUB: 1 for i=0, else carry register (the ALU computes A+~B+cin)
    - AND/OR: always 0
  - RUN, each edge:
    - result word i <= alu_result
    - carry <= alu_cout
    - zacc <= zacc & (alu_result==0)
    - i <= i+1
  - RUN → DONE on the edge where i = eff_len-1.
  - DONE, one cycle:
    - done=1, busy=0
    - If set_flags, flags <= {N,Z,C,V}, computed at the RUN→DONE edge:
      - N = msb of top word result
      - Z = zacc including top word
      - C = alu_cout of top word & ~op[1]
      - V = ~(op[0]^a_msb^b_msb) & (a_msb^sum_msb) & ~op[1], with a_msb, b_msb, sum_msb taken from top word i=eff_len-1
    - If set_flags=0, flags unchanged.
    - DONE → IDLE unconditionally. A start during DONE is ignored; it is accepted from IDLE next cycle.
- Latency: start edge to done high = eff_len+1 cycles; back-to-back throughput is one op per eff_len+2 cycles.
- Result words ≥ eff_len read 0.
- start while busy or in DONE is ignored and does not alter latched operands.
- Inputs a_in/b_in/len may change after acceptance without effect.
- Logic ops: C=V=0 by formula; N and Z still computed across words.

Test Plan:
- ADD, len=2, A=0x00000000_FFFFFFFF, B=0x00000000_00000001, set_flags=1 → result 0x00000001_00000000, flags 4'b0000, done exactly 3 cycles after start, alu_cin=1 on word 1.
- SUB, len=2, A=B=0x12345678_9ABCDEF0, S=1 → result 0, flags 4'b0110 (Z=1, C=1 no borrow); alu_cin=1 on word 0.
- ADD, len=2, A=0x7FFFFFFF_FFFFFFFF, B=1, S=1 → result 0x80000000_00000000, flags 4'b1001.
- SUB, len=1, A=0, B=1, S=1 → result 0x00000000_FFFFFFFF, flags 4'b1000, done 2 cycles after start; then AND, len=2, A=B=0xFFFF0000_0000FFFF, S=0 → result 0xFFFF0000_0000FFFF, flags stay 4'b1000.
- ADD, len=0 → treated as len=1 (done after 2 cycles). ADD, len=3 with WORDS=2 → treated as 2. start pulsed every cycle during RUN and DONE → exactly one operation; the next starts only from IDLE.
- Reset asserted in RUN after word 0 (prior flags 4'b1001) → next edge busy=0, done=0, result=0, flags=0, and no done pulse follows.
